// File: rtl/pll_supervisor.sv
// rtl/pll_supervisor.sv - per-channel PLL bring-up, lock debounce, retry and relock supervisor
// One independent FSM per channel; user_rst is released only when every channel is locked.
module pll_supervisor #(
  parameter int         N_PLL        = 1,
  parameter int         RST_HOLD     = 16,
  parameter int         LOCK_TIMEOUT = 65535,
  parameter int         LOCK_STABLE  = 256,
  parameter int         MAX_RETRY    = 3,
  parameter logic [5:0] ICPSEL_BASE  = 6'd16,
  parameter logic [5:0] ICPSEL_STEP  = 6'd4,
  parameter logic [2:0] LPFRES_INIT  = 3'd2
) (
  input  logic                 init_clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_PLL-1:0]     pll_lock,
  output logic [N_PLL-1:0]     pll_rst,
  output logic [6*N_PLL-1:0]   icpsel,
  output logic [3*N_PLL-1:0]   lpfres,
  output logic [N_PLL-1:0]     locked,
  output logic [N_PLL-1:0]     fail,
  output logic [4*N_PLL-1:0]   relock_cnt,
  output logic                 all_locked,
  output logic                 user_rst
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_WAIT, S_STABLE, S_LOCKED, S_FAIL
  } state_t;

  localparam int HW = $clog2(RST_HOLD) + 1;
  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int SW = $clog2(LOCK_STABLE) + 1;
  localparam int RW = $clog2(MAX_RETRY) + 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_HOLD - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STAB_LAST  = SW'(LOCK_STABLE - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

  logic [N_PLL-1:0]   sync1_q, lock_s_q;
  logic [3*N_PLL-1:0] lpfres_q;
  logic               all_locked_q, user_rst_q;

  always_ff @(posedge init_clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= '0;
      lock_s_q     <= '0;
      lpfres_q     <= {N_PLL{LPFRES_INIT}};
      all_locked_q <= 1'b0;
      user_rst_q   <= 1'b1;
    end else begin
      sync1_q      <= pll_lock;
      lock_s_q     <= sync1_q;
      lpfres_q     <= lpfres_q;
      all_locked_q <= &locked;
      user_rst_q   <= ~(&locked);
    end
  end

  assign lpfres     = lpfres_q;
  assign all_locked = all_locked_q;
  assign user_rst   = user_rst_q;

  for (genvar g = 0; g < N_PLL; g++) begin : g_ch
    state_t          state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [TW-1:0]   to_q, to_d;
    logic [SW-1:0]   stab_q, stab_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [5:0]      icp_q, icp_d;
    logic [3:0]      rcnt_q, rcnt_d;
    logic [6:0]      icp_sum;
    logic            lock_s;
    logic            pll_rst_q, locked_q, fail_q;

    assign lock_s  = lock_s_q[g];
    assign icp_sum = {1'b0, icp_q} + {1'b0, ICPSEL_STEP};

    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      to_d    = to_q;
      stab_d  = stab_q;
      retry_d = retry_q;
      icp_d   = icp_q;
      rcnt_d  = rcnt_q;
      // Dropping enable wins over every other transition, including a relock count.
      if (!enable) begin
        state_d = S_IDLE;
        hold_d  = '0;
        to_d    = '0;
        stab_d  = '0;
        retry_d = '0;
        icp_d   = ICPSEL_BASE;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_d = S_RST;
            hold_d  = '0;
          end
          S_RST: begin
            to_d = '0;
            if (hold_q == HOLD_LAST) state_d = S_WAIT;
            else                     hold_d  = hold_q + 1'b1;
          end
          S_WAIT, S_STABLE: begin
            to_d = to_q + 1'b1;
            if (to_q == TO_LAST) begin
              if (retry_q == RETRY_LAST) begin
                state_d = S_FAIL;
              end else begin
                state_d = S_RST;
                hold_d  = '0;
                retry_d = retry_q + 1'b1;
                icp_d   = icp_sum[6] ? 6'd63 : icp_sum[5:0];
              end
            end else if (state_q == S_WAIT) begin
              if (lock_s) begin
                state_d = S_STABLE;
                stab_d  = '0;
              end
            end else if (!lock_s) begin
              state_d = S_WAIT;
            end else if (stab_q == STAB_LAST) begin
              state_d = S_LOCKED;
            end else begin
              stab_d = stab_q + 1'b1;
            end
          end
          S_LOCKED: begin
            if (!lock_s) begin
              state_d = S_RST;
              hold_d  = '0;
              retry_d = '0;
              rcnt_d  = (rcnt_q == 4'd15) ? rcnt_q : rcnt_q + 4'd1;
            end
          end
          S_FAIL:  state_d = S_FAIL;
          default: state_d = S_IDLE;
        endcase
      end
    end

    // Outputs are registered from the next state so they change on the transition edge.
    always_ff @(posedge init_clk or posedge reset) begin
      if (reset) begin
        state_q   <= S_IDLE;
        hold_q    <= '0;
        to_q      <= '0;
        stab_q    <= '0;
        retry_q   <= '0;
        icp_q     <= ICPSEL_BASE;
        rcnt_q    <= '0;
        pll_rst_q <= 1'b1;
        locked_q  <= 1'b0;
        fail_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        hold_q    <= hold_d;
        to_q      <= to_d;
        stab_q    <= stab_d;
        retry_q   <= retry_d;
        icp_q     <= icp_d;
        rcnt_q    <= rcnt_d;
        pll_rst_q <= (state_d == S_IDLE) || (state_d == S_RST) || (state_d == S_FAIL);
        locked_q  <= (state_d == S_LOCKED);
        fail_q    <= (state_d == S_FAIL);
      end
    end

    assign pll_rst[g]         = pll_rst_q;
    assign locked[g]          = locked_q;
    assign fail[g]            = fail_q;
    assign icpsel[6*g +: 6]   = icp_q;
    assign relock_cnt[4*g +: 4] = rcnt_q;
  end

endmodule

// File: doc/pll_supervisor.md
# pll_supervisor

Parametrised multi-channel PLL bring-up and lock supervisor. It drives reset and charge-pump/loop-filter settings for N_PLL PLL macros and synchronises and debounces each lock output. On lock timeout it retries with a stepped charge-pump current, and on loss of lock it re-acquires automatically. It sits beside the PLL macros in the video/clock subsystem and supplies a single downstream reset that is released only when every channel is stably locked.

## Interface
- N_PLL, 1: number of supervised PLL channels (1..8)
- RST_HOLD, 16: cycles pll_rst is held high per attempt (≥1)
- LOCK_TIMEOUT, 65535: cycles allowed in WAIT+STABLE before an attempt fails (≥LOCK_STABLE+1)
- LOCK_STABLE, 256: consecutive synchronised-lock cycles required to declare lock (≥1)
- MAX_RETRY, 3: failed attempts tolerated before FAIL (0..15)
- ICPSEL_BASE, 6'd16: initial charge-pump select
- ICPSEL_STEP, 6'd4: increment applied per failed attempt, saturating at 63
- LPFRES_INIT, 3'd2: loop-filter resistor select, constant

Ports:
- init_clk  in  1  free-running supervisor clock
- reset  in  1  asynchronous, active-high
- enable  in  1  level; high = bring up PLLs, low = return to IDLE
- pll_lock  in  N_PLL  raw lock from each PLL, asynchronous to init_clk
- pll_rst  out  N_PLL  reset to each PLL, active-high
- icpsel  out  6*N_PLL  charge-pump select, channel i at [6i+5:6i]
- lpfres  out  3*N_PLL  loop-filter resistor, channel i at [3i+2:3i]
- locked  out  N_PLL  debounced lock per channel
- fail  out  N_PLL  channel exhausted its retries
- relock_cnt  out  4*N_PLL  saturating count of lock losses in LOCKED, per channel
- all_locked  out  1  every channel locked
- user_rst  out  1  downstream reset, active-high

## Operation
- Each pll_lock bit passes through a 2-flop synchroniser to give lock_s. Nothing uses the raw input.
- Each channel has an independent FSM: IDLE, RST, WAIT, STABLE, LOCKED, FAIL.
- IDLE: pll_rst=1. Clears retry, hold, timeout and stable counters. Sets icpsel=ICPSEL_BASE. Goes to RST when enable=1.
- RST: pll_rst=1 for exactly RST_HOLD cycles, then WAIT. Clears the timeout counter on entry.
- WAIT: pll_rst=0 and the timeout counter increments. lock_s=1 goes to STABLE and clears the stable counter.
- STABLE: the timeout counter keeps incrementing and the stable counter increments while lock_s=1.
  - lock_s=0 returns to WAIT.
  - When the stable counter reaches LOCK_STABLE, go to LOCKED.
- Timeout: in WAIT or STABLE, when the timeout counter reaches LOCK_TIMEOUT:
  - if retry==MAX_RETRY, go to FAIL;
  - otherwise retry+=1, icpsel=min(icpsel+ICPSEL_STEP, 63), go to RST.
  - Timeout has priority over a simultaneous STABLE completion.
- LOCKED: locked=1. lock_s=0 does all of the following: relock_cnt+=1 (saturates at 15), retry=0, icpsel unchanged, go to RST.
- FAIL: pll_rst=1, fail=1. The state is sticky until enable=0.
- enable=0 in any state: go to IDLE on the next edge. This takes priority over every other transition. relock_cnt is cleared only by reset.
- all_locked and user_rst are registered:
  - all_locked <= &locked
  - user_rst <= ~(&locked)
- Counter widths come from $clog2 of the corresponding parameter +1. No counter wraps.

## Timing
- Reset values: pll_rst all 1, icpsel=ICPSEL_BASE per channel, lpfres=LPFRES_INIT, locked=0, fail=0, relock_cnt=0, all_locked=0, user_rst=1. All FSMs are in IDLE.
- All outputs are registered. lpfres is constant after reset.
- enable rising at edge k: state=RST at edge k+1. pll_rst stays high through edge k+RST_HOLD and falls at edge k+RST_HOLD+1.
- pll_lock to lock_s latency is 2 cycles.
- Lock rise to locked rise is 2 (sync) + 1 (enter STABLE) + LOCK_STABLE cycles. A glitch shorter than LOCK_STABLE never sets locked.
- locked falls 3 cycles after pll_lock falls (2 sync + 1 transition). pll_rst rises on the same edge.
- all_locked and user_rst follow locked by exactly 1 cycle.
- Asserting reset mid-operation returns every output to its reset value immediately. Deassertion is synchronous to init_clk by upstream design.

## Test plan
- Basic lock, N_PLL=2, RST_HOLD=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, MAX_RETRY=2: enable=1, both pll_lock rise 5 cycles after pll_rst falls -> pll_rst high for exactly 4 cycles, locked rises 11 cycles after pll_lock, all_locked rises and user_rst falls 1 cycle later.
- Debounce: pll_lock pulses high for 5 cycles, then holds high -> locked stays 0 through the pulse, then asserts 11 cycles after the final rise.
- Retry stepping: pll_lock held 0 -> three RST attempts with icpsel=16, 20, 24, then fail=1 with pll_rst=1 on that channel while the other channel is unaffected; user_rst stays 1.
- Relock: after lock, drop pll_lock on channel 1 for 3 cycles -> locked[1] falls 3 cycles later, relock_cnt[1]=1, pll_rst[1] high for 4 cycles, icpsel unchanged, user_rst=1 until re-lock.
- Priority: in LOCKED, deassert enable on the same cycle pll_lock falls -> channel goes to IDLE (not RST), relock_cnt increment suppressed, icpsel=16.
- Async reset mid-WAIT: pulse reset -> all outputs return to reset values within the same cycle, relock_cnt=0, and bring-up restarts on the next enable.
